// File: rtl/motion_ctrl.sv
// Car drive-command stage: mode/motion FSM (manual, obstacle-avoid auto, 8-step dance)
// producing per-wheel direction bits and PWM enables from single-cycle command pulses.
module motion_ctrl #(
  parameter int unsigned PWM_PERIOD  = 100,
  parameter int unsigned PWM_DUTY    = 60,
  parameter int unsigned TURN_CYCLES = 5000,
  parameter int unsigned BACK_CYCLES = 5000,
  parameter int unsigned DANCE_STEP  = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       forward_op,
  input  logic       backward_op,
  input  logic       left_op,
  input  logic       right_op,
  input  logic       auto_op,
  input  logic       dance_op,
  input  logic       obstacle,
  output logic [1:0] mode,
  output logic [2:0] motion,
  output logic       dir_l,
  output logic       dir_r,
  output logic       pwm_l,
  output logic       pwm_r
);

  localparam int unsigned MAX_TB = (TURN_CYCLES > BACK_CYCLES) ? TURN_CYCLES : BACK_CYCLES;
  localparam int unsigned MAX_C  = (MAX_TB > DANCE_STEP) ? MAX_TB : DANCE_STEP;
  localparam int unsigned TW     = $clog2(MAX_C + 1);
  localparam int unsigned PW     = $clog2(PWM_PERIOD);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_DANCE  = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    MOT_STOP   = 3'd0,
    MOT_FWD    = 3'd1,
    MOT_BWD    = 3'd2,
    MOT_SPIN_L = 3'd3,
    MOT_SPIN_R = 3'd4
  } motion_e;

  typedef enum logic [1:0] {
    AUTO_DRIVE = 2'd0,
    AUTO_BACK  = 2'd1,
    AUTO_TURN  = 2'd2
  } auto_e;

  mode_e          mode_q, mode_d;
  motion_e        motion_q, motion_d;
  motion_e        saved_q, saved_d;
  auto_e          auto_q, auto_d;
  logic           spin_q, spin_d;
  logic [2:0]     step_q, step_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [PW-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic           dir_l_q, dir_l_d, dir_r_q, dir_r_d;
  logic           pwm_l_q, pwm_r_q, pwm_on_d;

  function automatic motion_e dance_motion(input logic [2:0] s);
    case (s)
      3'd0:    dance_motion = MOT_FWD;
      3'd1:    dance_motion = MOT_SPIN_L;
      3'd2:    dance_motion = MOT_BWD;
      3'd3:    dance_motion = MOT_SPIN_R;
      3'd4:    dance_motion = MOT_FWD;
      3'd5:    dance_motion = MOT_SPIN_R;
      3'd6:    dance_motion = MOT_BWD;
      default: dance_motion = MOT_SPIN_L;
    endcase
  endfunction

  function automatic logic is_spin(input motion_e m);
    is_spin = (m == MOT_SPIN_L) || (m == MOT_SPIN_R);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_MANUAL;
      motion_q  <= MOT_STOP;
      saved_q   <= MOT_STOP;
      auto_q    <= AUTO_DRIVE;
      spin_q    <= 1'b0;
      step_q    <= '0;
      timer_q   <= '0;
      pwm_cnt_q <= '0;
      dir_l_q   <= 1'b0;
      dir_r_q   <= 1'b0;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      motion_q  <= motion_d;
      saved_q   <= saved_d;
      auto_q    <= auto_d;
      spin_q    <= spin_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      pwm_cnt_q <= pwm_cnt_d;
      dir_l_q   <= dir_l_d;
      dir_r_q   <= dir_r_d;
      pwm_l_q   <= pwm_on_d;
      pwm_r_q   <= pwm_on_d;
    end
  end

  // Mode/motion next state; mode pulses pre-empt direction pulses
  always_comb begin
    mode_d   = mode_q;
    motion_d = motion_q;
    saved_d  = saved_q;
    auto_d   = auto_q;
    spin_d   = spin_q;
    step_d   = step_q;
    timer_d  = timer_q;

    if (dance_op || auto_op) begin
      timer_d = '0;
      step_d  = '0;
      spin_d  = 1'b0;
      auto_d  = AUTO_DRIVE;
      if (dance_op) begin
        mode_d   = (mode_q == MODE_DANCE) ? MODE_MANUAL : MODE_DANCE;
        motion_d = (mode_q == MODE_DANCE) ? MOT_STOP : MOT_FWD;
      end else begin
        mode_d   = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
        motion_d = (mode_q == MODE_AUTO) ? MOT_STOP : MOT_FWD;
      end
    end else begin
      case (mode_q)
        MODE_MANUAL: begin
          if (forward_op || backward_op) begin
            spin_d  = 1'b0;
            timer_d = '0;
            if (forward_op) motion_d = (motion_q == MOT_FWD) ? MOT_STOP : MOT_FWD;
            else            motion_d = (motion_q == MOT_BWD) ? MOT_STOP : MOT_BWD;
          end else if (left_op || right_op) begin
            // A spin interrupting a spin keeps the motion saved by the first one
            if (!spin_q) saved_d = is_spin(motion_q) ? MOT_STOP : motion_q;
            motion_d = left_op ? MOT_SPIN_L : MOT_SPIN_R;
            spin_d   = 1'b1;
            timer_d  = '0;
          end else if (spin_q) begin
            if (timer_q == TW'(TURN_CYCLES - 1)) begin
              motion_d = saved_q;
              spin_d   = 1'b0;
              timer_d  = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        MODE_AUTO: begin
          case (auto_q)
            AUTO_DRIVE: begin
              if (obstacle) begin
                auto_d   = AUTO_BACK;
                motion_d = MOT_BWD;
                timer_d  = '0;
              end
            end
            AUTO_BACK: begin
              if (timer_q == TW'(BACK_CYCLES - 1)) begin
                auto_d   = AUTO_TURN;
                motion_d = MOT_SPIN_R;
                timer_d  = '0;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
            default: begin
              if (timer_q == TW'(TURN_CYCLES - 1)) begin
                auto_d   = AUTO_DRIVE;
                motion_d = MOT_FWD;
                timer_d  = '0;
              end else begin
                timer_d = timer_q + TW'(1);
              end
            end
          endcase
        end
        MODE_DANCE: begin
          if (timer_q == TW'(DANCE_STEP - 1)) begin
            step_d   = step_q + 3'd1;
            motion_d = dance_motion(step_q + 3'd1);
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          mode_d   = MODE_MANUAL;
          motion_d = MOT_STOP;
          timer_d  = '0;
          step_d   = '0;
          spin_d   = 1'b0;
        end
      endcase
    end
  end

  // Wheel outputs track the motion being registered so they line up with motion
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PW'(1);
    pwm_on_d  = (motion_d != MOT_STOP) && (32'(pwm_cnt_q) < PWM_DUTY);
    dir_l_d   = 1'b0;
    dir_r_d   = 1'b0;
    case (motion_d)
      MOT_FWD:    begin dir_l_d = 1'b1; dir_r_d = 1'b1; end
      MOT_SPIN_L: begin dir_l_d = 1'b0; dir_r_d = 1'b1; end
      MOT_SPIN_R: begin dir_l_d = 1'b1; dir_r_d = 1'b0; end
      default:    begin dir_l_d = 1'b0; dir_r_d = 1'b0; end
    endcase
  end

  assign mode   = mode_q;
  assign motion = motion_q;
  assign dir_l  = dir_l_q;
  assign dir_r  = dir_r_q;
  assign pwm_l  = pwm_l_q;
  assign pwm_r  = pwm_r_q;

endmodule
